// File: rtl/c2f_sched.sv
// c2f_sched
// Runs one C2f stage (cv1 -> N bottlenecks -> concat -> cv2) as a fixed list of
// 2+2N commands on a single shared conv engine. The concat region is laid out
// so that cv1 writes x1/x2 into slots 0/1 and each bottleneck writes its result
// into the next slot. The final cv2 then reads slots 0..N+1 as one contiguous
// (2+N)*MID_CH-channel map, so the concat needs no data movement.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle request to run the stage (ignored while busy)
//   busy            high from the cycle after an accepted start until done
//   done            one-cycle pulse when the last op (cv2) completes
//   err             sticky protocol error (eng_done outside WAIT), cleared by
//                   the next accepted start
//   eng_valid/ready command handshake towards the conv engine
//   eng_k           kernel size (1 or 3), padding k/2, stride 1
//   eng_in_ch/out_ch channel counts of the command
//   eng_src/dst     feature-buffer base addresses of the command
//   eng_done        engine finished the last accepted command
//
// Optional build macro C2F_SCHED_PERF_EN adds:
//   perf_cycles     busy cycles of the last run (saturating)
//   perf_stall      cycles spent in ISSUE with eng_ready low (saturating)
module c2f_sched #(
  parameter int IN_CH     = 1,
  parameter int OUT_CH    = 1,
  parameter int MID_CH    = 1,
  parameter int N         = 1,
  parameter int MAP_WORDS = 1,
  parameter int ADDR_W    = 20,
  parameter int CH_W      = 12,
  parameter int IN_BASE   = 0,
  parameter int CAT_BASE  = 0,
  parameter int TMP_BASE  = 0,
  parameter int OUT_BASE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              eng_valid,
  input  logic              eng_ready,
  output logic [1:0]        eng_k,
  output logic [CH_W-1:0]   eng_in_ch,
  output logic [CH_W-1:0]   eng_out_ch,
  output logic [ADDR_W-1:0] eng_src,
  output logic [ADDR_W-1:0] eng_dst,
`ifdef C2F_SCHED_PERF_EN
  input  logic              eng_done,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`else
  input  logic              eng_done
`endif
);

  // Op index needs to reach 2+2*4-1 = 9.
  localparam int OP_W = 4;

  // Elaboration-time range checks, done in 64-bit arithmetic.
  localparam longint unsigned ADDR_LIM   = 64'd1 << ADDR_W;
  localparam longint unsigned CH_LIM     = 64'd1 << CH_W;
  localparam longint unsigned SLOT_L     = 64'(MID_CH) * 64'(MAP_WORDS);
  localparam longint unsigned MAX_SLOT_L = 64'(CAT_BASE) + 64'(N + 1) * SLOT_L;
  localparam longint unsigned CAT_CH_L   = 64'(N + 2) * 64'(MID_CH);

  localparam logic [ADDR_W-1:0] SLOT_A    = ADDR_W'(SLOT_L);
  localparam logic [ADDR_W-1:0] IN_A      = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] CAT_A     = ADDR_W'(CAT_BASE);
  localparam logic [ADDR_W-1:0] TMP_A     = ADDR_W'(TMP_BASE);
  localparam logic [ADDR_W-1:0] OUT_A     = ADDR_W'(OUT_BASE);
  localparam logic [CH_W-1:0]   IN_C      = CH_W'(IN_CH);
  localparam logic [CH_W-1:0]   OUT_C     = CH_W'(OUT_CH);
  localparam logic [CH_W-1:0]   MID_C     = CH_W'(MID_CH);
  localparam logic [CH_W-1:0]   CV1_OUT_C = CH_W'(2 * MID_CH);
  localparam logic [CH_W-1:0]   CAT_C     = CH_W'(CAT_CH_L);
  localparam logic [OP_W-1:0]   LAST_OP   = OP_W'(2 * N + 1);

  if ((N < 1) || (N > 4)) begin : g_bad_n
    $error("c2f_sched: N=%0d is outside 1..4", N);
  end

  if ((64'(IN_BASE) >= ADDR_LIM) || (64'(TMP_BASE) >= ADDR_LIM) ||
      (64'(OUT_BASE) >= ADDR_LIM) || (MAX_SLOT_L >= ADDR_LIM)) begin : g_bad_addr
    $error("c2f_sched: a base or concat slot address does not fit in ADDR_W=%0d", ADDR_W);
  end

  if ((64'(IN_CH) >= CH_LIM) || (64'(OUT_CH) >= CH_LIM) ||
      (64'(2 * MID_CH) >= CH_LIM) || (CAT_CH_L >= CH_LIM)) begin : g_bad_ch
    $error("c2f_sched: a channel count does not fit in CH_W=%0d", CH_W);
  end

  typedef struct packed {
    logic [1:0]        k;
    logic [CH_W-1:0]   in_ch;
    logic [CH_W-1:0]   out_ch;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
  } cmd_t;

  localparam int   CMD_BITS = 2 + 2 * CH_W + 2 * ADDR_W;
  localparam cmd_t CMD_ZERO = cmd_t'({CMD_BITS{1'b0}});

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [OP_W-1:0] op_r;
  cmd_t            cmd_r;
  logic            busy_r;
  logic            done_r;
  logic            err_r;
  logic            valid_r;

  // Command fields for one op index. Ops 1..2N alternate bottleneck cv1
  // (slot(1+i) -> TMP) and cv2 (TMP -> slot(2+i)); with rel = op-1 the slot
  // touched by either half is (rel>>1) + 1 + rel[0].
  function automatic cmd_t decode(input logic [OP_W-1:0] op);
    cmd_t            c;
    logic [OP_W-1:0] rel;
    logic [OP_W-1:0] idx;
    logic [ADDR_W-1:0] sl;
    c   = CMD_ZERO;
    rel = op - 4'd1;
    idx = (rel >> 1) + 4'd1 + {3'b000, rel[0]};
    sl  = CAT_A + SLOT_A * ADDR_W'(idx);
    if (op == 4'd0) begin
      c.k      = 2'd1;
      c.in_ch  = IN_C;
      c.out_ch = CV1_OUT_C;
      c.src    = IN_A;
      c.dst    = CAT_A;
    end else if (op == LAST_OP) begin
      c.k      = 2'd1;
      c.in_ch  = CAT_C;
      c.out_ch = OUT_C;
      c.src    = CAT_A;
      c.dst    = OUT_A;
    end else begin
      c.k      = 2'd3;
      c.in_ch  = MID_C;
      c.out_ch = MID_C;
      if (rel[0] == 1'b0) begin
        c.src = sl;
        c.dst = TMP_A;
      end else begin
        c.src = TMP_A;
        c.dst = sl;
      end
    end
    return c;
  endfunction

  // Sequencer: walks the op list, issues each command and waits for completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      op_r    <= 4'd0;
      cmd_r   <= CMD_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_ISSUE;
            op_r    <= 4'd0;
            busy_r  <= 1'b1;
            valid_r <= 1'b1;
            cmd_r   <= decode(4'd0);
            // A completion arriving in the same cycle is still spurious.
            err_r   <= eng_done;
          end else if (eng_done) begin
            err_r <= 1'b1;
          end
        end
        S_ISSUE: begin
          // No command is outstanding here, so any completion is spurious,
          // including one that coincides with the handshake.
          if (eng_done) begin
            err_r <= 1'b1;
          end
          if (eng_ready) begin
            state_r <= S_WAIT;
            valid_r <= 1'b0;
            cmd_r   <= CMD_ZERO;
          end
        end
        S_WAIT: begin
          if (eng_done) begin
            if (op_r == LAST_OP) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_ISSUE;
              op_r    <= op_r + 4'd1;
              valid_r <= 1'b1;
              cmd_r   <= decode(op_r + 4'd1);
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
          cmd_r   <= CMD_ZERO;
        end
      endcase
    end
  end

`ifdef C2F_SCHED_PERF_EN
  logic [31:0] perf_cycles_r;
  logic [31:0] perf_stall_r;

  // Saturating run statistics, cleared on an accepted start, frozen while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_r <= 32'd0;
      perf_stall_r  <= 32'd0;
    end else if ((state_r == S_IDLE) && start) begin
      perf_cycles_r <= 32'd0;
      perf_stall_r  <= 32'd0;
    end else begin
      if (busy_r && (perf_cycles_r != 32'hFFFF_FFFF)) begin
        perf_cycles_r <= perf_cycles_r + 32'd1;
      end
      if ((state_r == S_ISSUE) && !eng_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_r;
  assign perf_stall  = perf_stall_r;
`endif

  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign eng_valid  = valid_r;
  assign eng_k      = cmd_r.k;
  assign eng_in_ch  = cmd_r.in_ch;
  assign eng_out_ch = cmd_r.out_ch;
  assign eng_src    = cmd_r.src;
  assign eng_dst    = cmd_r.dst;

endmodule

// File: tb/tb_c2f_sched.sv
// Bench for c2f_sched. Two instances: N=2 (main) and N=1. A small engine model
// accepts commands and pulses eng_done two cycles after the accept cycle.
module tb_c2f_sched;

  localparam int IN_CH  = 8;
  localparam int OUT_CH = 16;
  localparam int MID    = 4;
  localparam int MAPW   = 16;
  localparam int IN_B   = 'h10;
  localparam int CAT_B  = 'h100;
  localparam int TMP_B  = 'h400;
  localparam int OUT_B  = 'h800;
  localparam int SLOT   = MID * MAPW;

  typedef struct {
    int k;
    int in_ch;
    int out_ch;
    int src;
    int dst;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n, start, start1, eng_ready, eng1_ready, spur_done;
  logic e0_done, e1_done, eng_done;
  logic busy, done, err, eng_valid;
  logic [1:0] eng_k;
  logic [11:0] eng_in_ch, eng_out_ch;
  logic [19:0] eng_src, eng_dst;
  logic b1_busy, b1_done, b1_err, b1_valid;
  logic [1:0] b1_k;
  logic [11:0] b1_in_ch, b1_out_ch;
  logic [19:0] b1_src, b1_dst;
`ifdef C2F_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall, b1_pc, b1_ps;
`endif

  int cyc = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  int total = 0;
  int bad = 0;
  int run_id = 0;
  int seen_run = 0;
  int acc = 0;
  int dones = 0;
  bit prev_stall = 1'b0;
  cmd_t prev_c;
  cmd_t exp_q[$];
  cmd_t exp1_q[$];
  cmd_t obs[$];
  cmd_t obs1[$];

  assign eng_done = e0_done | spur_done;

  always #5 clk = ~clk;

  c2f_sched #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .MID_CH(MID), .N(2), .MAP_WORDS(MAPW),
              .ADDR_W(20), .CH_W(12), .IN_BASE(IN_B), .CAT_BASE(CAT_B),
              .TMP_BASE(TMP_B), .OUT_BASE(OUT_B)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_k(eng_k),
    .eng_in_ch(eng_in_ch), .eng_out_ch(eng_out_ch), .eng_src(eng_src), .eng_dst(eng_dst),
`ifdef C2F_SCHED_PERF_EN
    .perf_cycles(perf_cycles), .perf_stall(perf_stall),
`endif
    .eng_done(eng_done)
  );

  c2f_sched #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .MID_CH(MID), .N(1), .MAP_WORDS(MAPW),
              .ADDR_W(20), .CH_W(12), .IN_BASE(IN_B), .CAT_BASE(CAT_B),
              .TMP_BASE(TMP_B), .OUT_BASE(OUT_B)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(b1_busy), .done(b1_done), .err(b1_err),
    .eng_valid(b1_valid), .eng_ready(eng1_ready), .eng_k(b1_k),
    .eng_in_ch(b1_in_ch), .eng_out_ch(b1_out_ch), .eng_src(b1_src), .eng_dst(b1_dst),
`ifdef C2F_SCHED_PERF_EN
    .perf_cycles(b1_pc), .perf_stall(b1_ps),
`endif
    .eng_done(e1_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Engine models: eng_done pulses during the second cycle after the accept cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt0 <= 0;
      cnt1 <= 0;
      e0_done <= 1'b0;
      e1_done <= 1'b0;
    end else begin
      e0_done <= (cnt0 == 1);
      e1_done <= (cnt1 == 1);
      if (cnt0 > 0) cnt0 <= cnt0 - 1;
      if (cnt1 > 0) cnt1 <= cnt1 - 1;
      if (eng_valid && eng_ready) cnt0 <= 2;
      if (b1_valid && eng1_ready) cnt1 <= 2;
    end
  end

  // Records the commands accepted by the N=1 instance.
  always @(negedge clk) begin
    if (b1_valid && eng1_ready)
      obs1.push_back('{int'(b1_k), int'(b1_in_ch), int'(b1_out_ch), int'(b1_src), int'(b1_dst)});
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected command list straight from the op-list rules.
  task automatic build_exp(input int n, output cmd_t q[$]);
    q.delete();
    q.push_back('{1, IN_CH, 2 * MID, IN_B, CAT_B});
    for (int i = 0; i < n; i++) begin
      q.push_back('{3, MID, MID, CAT_B + (1 + i) * SLOT, TMP_B});
      q.push_back('{3, MID, MID, TMP_B, CAT_B + (2 + i) * SLOT});
    end
    q.push_back('{1, (2 + n) * MID, OUT_CH, CAT_B, OUT_B});
  endtask

  function automatic bit same(input cmd_t a, input cmd_t b);
    return (a.k == b.k) && (a.in_ch == b.in_ch) && (a.out_ch == b.out_ch) &&
           (a.src == b.src) && (a.dst == b.dst);
  endfunction

  task automatic pulse_start(input bit which, output int t);
    if (!which) run_id = run_id + 1;
    @(negedge clk);
    @(posedge clk); #2;
    if (which) start1 = 1'b1; else start = 1'b1;
    t = cyc;
    @(posedge clk); #2;
    start = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int t, input int lat);
    bit got;
    int dc;
    got = 1'b0;
    dc = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dc = cyc;
        break;
      end
    end
    chk({nm, " done seen"}, got, 1);
    if (got) begin
      chk({nm, " done cycle"}, dc - t, lat);
      chk({nm, " busy at done"}, busy, 0);
    end
    @(negedge clk);
    chk({nm, " done width"}, done, 0);
    repeat (3) @(negedge clk);
    chk({nm, " cmd count"}, acc, exp_q.size());
    chk({nm, " done pulses"}, dones, 1);
  endtask

  task automatic wait_acc_idle(input int n);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (acc >= n && !eng_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait op accepted", ok, 1);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (eng_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wait eng_valid", ok, 1);
  endtask

  initial begin
    int t;
    int lk[6];
    int ls[6];
    int ld[6];
    bit got1;
    int dc1;
    lk = '{1, 3, 3, 3, 3, 1};
    ls = '{'h10, 'h140, 'h400, 'h180, 'h400, 'h100};
    ld = '{'h100, 'h400, 'h180, 'h400, 'h1C0, 'h800};
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    eng_ready = 1'b1; eng1_ready = 1'b1; spur_done = 1'b0;
    build_exp(2, exp_q);
    build_exp(1, exp1_q);

    // Compare process: every cycle, fields are zero when idle, held while
    // stalled, and each issued command matches the next expected one.
    fork
      forever begin
        cmd_t cur;
        @(negedge clk);
        if (run_id != seen_run) begin
          seen_run = run_id;
          acc = 0;
          dones = 0;
          prev_stall = 1'b0;
          obs.delete();
        end
        if (!rst_n) prev_stall = 1'b0;
        cur = '{int'(eng_k), int'(eng_in_ch), int'(eng_out_ch), int'(eng_src), int'(eng_dst)};
        if (!eng_valid) begin
          chk("fields zero when idle", longint'(|{eng_k, eng_in_ch, eng_out_ch, eng_src, eng_dst}), 0);
        end else begin
          if (prev_stall) chk("fields stable in stall", same(cur, prev_c), 1);
          if (acc < exp_q.size()) begin
            chk($sformatf("op%0d k", acc), cur.k, exp_q[acc].k);
            chk($sformatf("op%0d in_ch", acc), cur.in_ch, exp_q[acc].in_ch);
            chk($sformatf("op%0d out_ch", acc), cur.out_ch, exp_q[acc].out_ch);
            chk($sformatf("op%0d src", acc), cur.src, exp_q[acc].src);
            chk($sformatf("op%0d dst", acc), cur.dst, exp_q[acc].dst);
          end else begin
            chk("extra command", acc, exp_q.size());
          end
          if (eng_ready) begin
            obs.push_back(cur);
            acc = acc + 1;
            prev_stall = 1'b0;
          end else begin
            prev_stall = 1'b1;
            prev_c = cur;
          end
        end
        if (done) dones = dones + 1;
      end
    join_none

    // Reset state.
    repeat (2) @(posedge clk); #2;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset valid", eng_valid, 0);
    chk("reset fields", longint'(|{eng_k, eng_in_ch, eng_out_ch, eng_src, eng_dst}), 0);
    rst_n = 1'b1;

    // Basic run, zero-latency engine.
    pulse_start(1'b0, t);
    @(negedge clk);
    chk("basic busy t+1", busy, 1);
    chk("basic valid t+1", eng_valid, 1);
    wait_done("basic", t, 19);
    for (int i = 0; i < 6; i++) begin
      if (i < obs.size()) begin
        chk($sformatf("basic lit k%0d", i), obs[i].k, lk[i]);
        chk($sformatf("basic lit src%0d", i), obs[i].src, ls[i]);
        chk($sformatf("basic lit dst%0d", i), obs[i].dst, ld[i]);
      end else begin
        chk($sformatf("basic lit missing%0d", i), obs.size(), 6);
      end
    end
    if (obs.size() == 6) chk("basic last in_ch", obs[5].in_ch, 16);
    chk("basic err", err, 0);
`ifdef C2F_SCHED_PERF_EN
    chk("basic perf_cycles", perf_cycles, 18);
    chk("basic perf_stall", perf_stall, 0);
`endif

    // eng_ready low for 5 cycles on op1.
    pulse_start(1'b0, t);
    wait_acc_idle(1);
    @(posedge clk); #2;
    eng_ready = 1'b0;
    @(negedge clk);
    wait_valid();
    repeat (5) @(posedge clk);
    #2;
    eng_ready = 1'b1;
    wait_done("stall", t, 24);
`ifdef C2F_SCHED_PERF_EN
    chk("stall perf_stall", perf_stall, 5);
    chk("stall perf_cycles", perf_cycles, 23);
`endif

    // Second start during op2 is ignored.
    pulse_start(1'b0, t);
    wait_acc_idle(2);
    wait_valid();
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("restart", t, 19);

    // Spurious eng_done while op1 waits in ISSUE.
    pulse_start(1'b0, t);
    wait_acc_idle(1);
    @(posedge clk); #2;
    eng_ready = 1'b0;
    @(negedge clk);
    wait_valid();
    @(posedge clk); #2;
    spur_done = 1'b1;
    @(posedge clk); #2;
    spur_done = 1'b0;
    eng_ready = 1'b1;
    @(negedge clk);
    chk("spurious err set", err, 1);
    wait_done("spurious", t, 21);
    chk("spurious err sticky", err, 1);

    // Next start clears err.
    pulse_start(1'b0, t);
    @(negedge clk);
    chk("err cleared", err, 0);
    wait_done("after err", t, 19);

    // Reset during WAIT of op3, then a fresh run from op0.
    pulse_start(1'b0, t);
    wait_acc_idle(4);
    @(posedge clk); #2;
    chk("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst err", err, 0);
    chk("async rst valid", eng_valid, 0);
    chk("async rst fields", longint'(|{eng_k, eng_in_ch, eng_out_ch, eng_src, eng_dst}), 0);
`ifdef C2F_SCHED_PERF_EN
    chk("async rst perf", longint'(|{perf_cycles, perf_stall}), 0);
`endif
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no done after reset", dones, 0);
    pulse_start(1'b0, t);
    wait_done("post-reset", t, 19);

    // N=1 instance.
    pulse_start(1'b1, t);
    got1 = 1'b0;
    dc1 = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b1_done) begin
        got1 = 1'b1;
        dc1 = cyc;
        break;
      end
    end
    chk("n1 done seen", got1, 1);
    if (got1) chk("n1 done cycle", dc1 - t, 13);
    chk("n1 cmd count", obs1.size(), 4);
    if (obs1.size() == 4) begin
      chk("n1 lit cv2 in_ch", obs1[3].in_ch, 12);
      chk("n1 lit b0 src", obs1[1].src, 'h140);
      chk("n1 lit b0 dst", obs1[2].dst, 'h180);
      for (int i = 0; i < 4; i++) chk($sformatf("n1 op%0d", i), same(obs1[i], exp1_q[i]), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c2f_sched.md
# c2f_sched

Sequencer that runs one C2f stage (cv1 → N bottlenecks → concat → cv2) on a single shared conv engine instead of dedicated per-layer hardware. It walks the fixed 2+2N op list, issues one command per op (kernel size, channel counts, buffer base addresses), and waits for the engine's completion before issuing the next. It sits between the network-level layer controller (start/done) and the shared conv engine plus feature buffer. It also places concat slots so the concat needs no data movement.

## Interface
Parameters:
- IN_CH, 1, input channels of the stage
- OUT_CH, 1, output channels of cv2
- MID_CH, 1, hidden channels per split
- N, 1, bottleneck count, legal 1..4
- MAP_WORDS, 1, words per channel map (IN_H*IN_W)
- ADDR_W, 20, feature-buffer word-address width
- CH_W, 12, channel-count field width
- IN_BASE, 0, input map base address
- CAT_BASE, 0, concat region base address
- TMP_BASE, 0, bottleneck scratch base address
- OUT_BASE, 0, output map base address

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run the stage
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when cv2 completes
- err  out  1  sticky protocol error, cleared by the next accepted start
- eng_valid  out  1  command valid
- eng_ready  in  1  engine accepts the command
- eng_k  out  2  kernel size, 1 or 3; padding = k/2, stride 1
- eng_in_ch  out  CH_W  input channels
- eng_out_ch  out  CH_W  output channels
- eng_src  out  ADDR_W  source base address
- eng_dst  out  ADDR_W  destination base address
- eng_done  in  1  engine finished the last accepted command

## Operation
- Reset: every output is 0. State is IDLE, op index is 0, err is 0.
- SLOT = MID_CH*MAP_WORDS. Concat slot j lives at CAT_BASE + j*SLOT.
- Op list, in order:
  - op0 cv1: k=1, in IN_CH, out 2*MID_CH, src IN_BASE, dst slot0. This fills x1 at slot0 and x2 at slot1.
  - For i in 0..N-1, bottleneck i runs two ops:
    - cv1: k=3, in/out MID_CH, src slot(1+i), dst TMP_BASE.
    - cv2: k=3, in/out MID_CH, src TMP_BASE, dst slot(2+i).
  - Last op cv2: k=1, in (2+N)*MID_CH, out OUT_CH, src slot0, dst OUT_BASE.
- The bottlenecks have no shortcut add.
- Command fields are registered and decoded from the op index. They are 0 whenever eng_valid is 0.
- State machine:
  - IDLE: start → ISSUE, with op index 0, busy=1, err cleared.
  - ISSUE: eng_valid=1 and the fields stay stable until eng_ready is sampled high; then → WAIT.
  - WAIT: on eng_done, if the op is the last one → DONE; otherwise increment the op index and go → ISSUE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Boundaries:
  - start while busy is ignored and is not queued.
  - eng_done in IDLE or ISSUE sets err and is otherwise ignored.
  - eng_done in the same cycle as eng_ready (ISSUE) also sets err.
  - N outside 1..4, or any address/channel field overflowing its width, causes an elaboration-time $error.
  - Reset asserted mid-run returns immediately to IDLE with all outputs 0. No done pulse is produced.

## Timing
- start at cycle t → busy and eng_valid at t+1.
- Command handshake completes on the first cycle where eng_valid && eng_ready.
- From eng_done at cycle u:
  - next eng_valid at u+1, or
  - done at u+1 for the last op; busy falls at u+1.
- With a zero-latency engine (ready immediately, done one cycle after accept), a full stage takes 3*(2+2N)+1 cycles from start to done.

## Configuration
- C2F_SCHED_PERF_EN defined: adds the ports
  - perf_cycles  out  32: busy-cycle count of the last run; frozen at done, cleared at the next accepted start.
  - perf_stall  out  32: cycles spent in ISSUE with eng_ready low, same update rules.
- Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and their counters do not exist. Behaviour is otherwise identical.

## Test plan
- N=2, MID_CH=4, MAP_WORDS=16, CAT_BASE=0x100, eng_ready always 1, done 1 cycle after accept:
  - Exactly 6 commands in order.
  - k and src/dst: (1,IN_BASE,0x100), (3,0x140,TMP), (3,TMP,0x180), (3,0x180,TMP), (3,TMP,0x1C0), (1,0x100,OUT_BASE).
  - Last op in_ch is 16.
  - done at cycle 19 after start.
- eng_ready held low for 5 cycles on op1 → eng_valid and all fields stable for those cycles; perf_stall=5 with PERF_EN.
- start pulsed again during op2 → ignored: same 6 commands, a single done pulse.
- Spurious eng_done in ISSUE → err=1, sequence continues unchanged; err clears on the next start.
- rst_n low during WAIT of op3 → all outputs 0 asynchronously, no done. A fresh start then reissues from op0.
- N=1 → exactly 4 commands; cv2 in_ch = 3*MID_CH.
